// File: rtl/mem_access_unit.sv
// Memory stage for LEGv8 LDUR/STUR: forms base+offset, runs a valid/ready
// request to data memory and returns load data with a one-cycle done pulse.
module mem_access_unit #(
    parameter int DATA_W     = 64,
    parameter int ALIGN_BITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] offset,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   eff_addr;

    // Carry-out is intentionally dropped: the address wraps modulo 2^DATA_W.
    assign eff_addr = base + offset;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    we_d    = is_store;
                    addr_d  = eff_addr;
                    wdata_d = wdata;
                    if (|eff_addr[ALIGN_BITS-1:0]) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) state_d = we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = mem_rsp_data;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Request valid is decoded from state so an async reset drops it at once.
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign rdata         = rdata_q;
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;

endmodule
